// File: rtl/head_table_lookup.sv
// Front stage of the search pipeline: hashes a command key to a bucket, reads the bucket's head
// pointer from the internal head table and emits a task {cmd, bucket, head_ptr, head_ptr_val}.
module head_table_lookup #(
  parameter int unsigned KEY_WIDTH    = 32,
  parameter int unsigned VALUE_WIDTH  = 32,
  parameter int unsigned OP_WIDTH     = 2,
  parameter int unsigned BUCKET_WIDTH = 8,
  parameter int unsigned A_WIDTH      = 10,
  // cmd_i  = {opcode, value, key}                      (key in the LSBs)
  // task_o = {cmd, bucket, head_ptr, head_ptr_val}     (head_ptr_val in bit 0)
  localparam int unsigned CMD_WIDTH  = OP_WIDTH + VALUE_WIDTH + KEY_WIDTH,
  localparam int unsigned TASK_WIDTH = CMD_WIDTH + BUCKET_WIDTH + A_WIDTH + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [CMD_WIDTH-1:0]    cmd_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    head_wr_en_i,
  input  logic [BUCKET_WIDTH-1:0] head_wr_bucket_i,
  input  logic [A_WIDTH-1:0]      head_wr_ptr_i,
  input  logic                    head_wr_ptr_val_i,
  output logic [TASK_WIDTH-1:0]   task_o,
  output logic                    task_valid_o,
  input  logic                    task_ready_i,
  output logic                    init_done_o
);

  localparam int unsigned DEPTH      = 2 ** BUCKET_WIDTH;
  localparam int unsigned NUM_CHUNKS = (KEY_WIDTH + BUCKET_WIDTH - 1) / BUCKET_WIDTH;
  localparam int unsigned HEAD_WIDTH = A_WIDTH + 1;

  localparam logic [0:0] INIT_S = 1'b0;
  localparam logic [0:0] RUN_S  = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [BUCKET_WIDTH-1:0] init_cnt_q, init_cnt_d;

  logic [HEAD_WIDTH-1:0]   mem_q [DEPTH];
  logic [HEAD_WIDTH-1:0]   rd_data_q;

  logic                    s1_valid_q, s1_valid_d;
  logic [CMD_WIDTH-1:0]    s1_cmd_q, s1_cmd_d;
  logic [BUCKET_WIDTH-1:0] s1_bucket_q, s1_bucket_d;
  logic                    s1_fresh_q, s1_fresh_d;
  logic [HEAD_WIDTH-1:0]   s1_head_q, s1_head_d;

  logic                    s2_valid_q, s2_valid_d;
  logic [TASK_WIDTH-1:0]   task_q, task_d;

  logic [NUM_CHUNKS*BUCKET_WIDTH-1:0] key_pad;
  logic [BUCKET_WIDTH-1:0] hash;
  logic                    run, wr_run, wr_hit_new, wr_hit_s1;
  logic                    s2_load, accept;
  logic [HEAD_WIDTH-1:0]   wr_data, s1_head, s1_fwd;
  logic                    ram_we;
  logic [BUCKET_WIDTH-1:0] ram_waddr;
  logic [HEAD_WIDTH-1:0]   ram_wdata;

  always_comb begin
    key_pad = '0;
    key_pad[KEY_WIDTH-1:0] = cmd_i[KEY_WIDTH-1:0];
    hash = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      hash = hash ^ key_pad[i*BUCKET_WIDTH +: BUCKET_WIDTH];
    end
  end

  assign run     = (state_q == RUN_S);
  assign wr_run  = run && head_wr_en_i;
  assign wr_data = {head_wr_ptr_i, head_wr_ptr_val_i};

  assign ram_we    = !run || wr_run;
  assign ram_waddr = run ? head_wr_bucket_i : init_cnt_q;
  assign ram_wdata = run ? wr_data : '0;

  // Read-during-write to the same bucket returns old data; forwarding below covers it.
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      mem_q[ram_waddr] <= ram_wdata;
    end
    rd_data_q <= mem_q[hash];
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT_S) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (&init_cnt_q) begin
        state_d = RUN_S;
      end
    end
  end

  assign s2_load     = !s2_valid_q || task_ready_i;
  assign cmd_ready_o = run && (!s1_valid_q || s2_load);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign wr_hit_new  = wr_run && (head_wr_bucket_i == hash);
  assign wr_hit_s1   = wr_run && (head_wr_bucket_i == s1_bucket_q);
  assign s1_head     = s1_fresh_q ? rd_data_q : s1_head_q;
  assign s1_fwd      = wr_hit_s1 ? wr_data : s1_head;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_cmd_d    = s1_cmd_q;
    s1_bucket_d = s1_bucket_q;
    s1_fresh_d  = s1_fresh_q;
    s1_head_d   = s1_head_q;
    s2_valid_d  = s2_valid_q;
    task_d      = task_q;

    if (accept) begin
      s1_valid_d  = 1'b1;
      s1_cmd_d    = cmd_i;
      s1_bucket_d = hash;
      // A same-cycle write supersedes the stale RAM read.
      s1_fresh_d  = !wr_hit_new;
      s1_head_d   = wr_data;
    end else if (s1_valid_q && s2_load) begin
      s1_valid_d = 1'b0;
      s1_fresh_d = 1'b0;
    end else if (s1_valid_q) begin
      s1_head_d  = s1_fwd;
      s1_fresh_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        task_d = {s1_cmd_q, s1_bucket_q, s1_fwd};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= INIT_S;
      init_cnt_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_cmd_q    <= '0;
      s1_bucket_q <= '0;
      s1_fresh_q  <= 1'b0;
      s1_head_q   <= '0;
      s2_valid_q  <= 1'b0;
      task_q      <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_cmd_q    <= s1_cmd_d;
      s1_bucket_q <= s1_bucket_d;
      s1_fresh_q  <= s1_fresh_d;
      s1_head_q   <= s1_head_d;
      s2_valid_q  <= s2_valid_d;
      task_q      <= task_d;
    end
  end

  assign task_o       = task_q;
  assign task_valid_o = s2_valid_q;
  assign init_done_o  = run;

endmodule

// File: tb/tb_head_table_lookup.sv
// Bench for head_table_lookup: scoreboard of expected tasks built from a bench-side hash and
// head-table model, checked as the DUT hands tasks downstream.
module tb_head_table_lookup;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [65:0] cmd_i = '0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        head_wr_en_i = 1'b0;
  logic [7:0]  head_wr_bucket_i = '0;
  logic [9:0]  head_wr_ptr_i = '0;
  logic        head_wr_ptr_val_i = 1'b0;
  logic [84:0] task_o;
  logic        task_valid_o;
  logic        task_ready_i = 1'b0;
  logic        init_done_o;

  int checks = 0;
  int failures = 0;

  logic [10:0] head_model [256];
  logic [84:0] exp_q [$];

  always #5 clk_i = ~clk_i;

  head_table_lookup dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .cmd_i             (cmd_i),
    .cmd_valid_i       (cmd_valid_i),
    .cmd_ready_o       (cmd_ready_o),
    .head_wr_en_i      (head_wr_en_i),
    .head_wr_bucket_i  (head_wr_bucket_i),
    .head_wr_ptr_i     (head_wr_ptr_i),
    .head_wr_ptr_val_i (head_wr_ptr_val_i),
    .task_o            (task_o),
    .task_valid_o      (task_valid_o),
    .task_ready_i      (task_ready_i),
    .init_done_o       (init_done_o)
  );

  function automatic logic [7:0] model_hash(input logic [31:0] k);
    return k[7:0] ^ k[15:8] ^ k[23:16] ^ k[31:24];
  endfunction

  function automatic logic [84:0] expected_task(input logic [65:0] c);
    logic [7:0] b;
    b = model_hash(c[31:0]);
    return {c, b, head_model[b]};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 256; i++) head_model[i] = '0;
  endtask

  task automatic wait_init(input string name);
    int cyc = 0;
    bit early_ready = 0;
    while (!init_done_o && cyc < 400) begin
      @(posedge clk_i); #1;
      cyc++;
      if (!init_done_o && cmd_ready_o) early_ready = 1;
    end
    checks++;
    if (cyc !== 256) begin
      failures++;
      $display("FAIL %s_init_cycles: got %0d expected 256", name, cyc);
    end
    checks++;
    if (early_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_ready_during_init: got %0b expected 0", name, early_ready);
    end
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_after_init: got %0b expected 1", name, cmd_ready_o);
    end
  endtask

  task automatic test_reset();
    clear_model();
    rst_i = 1'b1;
    #12;
    checks++;
    if ({cmd_ready_o, task_valid_o, init_done_o} !== 3'b000 || task_o !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%0b tv=%0b done=%0b task=%h expected all 0",
               cmd_ready_o, task_valid_o, init_done_o, task_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    wait_init("reset");
  endtask

  // Single command through an idle pipeline; checks 2-cycle latency and one-shot output.
  task automatic single_cmd(input string name, input logic [65:0] c, input logic [7:0] exp_b,
                            input logic [10:0] exp_head);
    logic [84:0] e;
    @(posedge clk_i); #1;
    cmd_valid_i  = 1'b1;
    cmd_i        = c;
    task_ready_i = 1'b1;
    @(posedge clk_i);
    exp_q.push_back(expected_task(c));
    #1;
    cmd_valid_i = 1'b0;
    checks++;
    if (task_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_early_valid: got %0b expected 0", name, task_valid_o);
    end
    @(posedge clk_i); #1;
    e = exp_q.pop_front();
    checks++;
    if (task_valid_o !== 1'b1 || task_o !== e) begin
      failures++;
      $display("FAIL %s_task: got v=%0b task=%h expected v=1 task=%h", name, task_valid_o, task_o, e);
    end
    checks++;
    if (task_o[18:11] !== exp_b || task_o[10:0] !== exp_head) begin
      failures++;
      $display("FAIL %s_fields: got bucket=%h head=%h expected bucket=%h head=%h",
               name, task_o[18:11], task_o[10:0], exp_b, exp_head);
    end
    @(posedge clk_i); #1;
    checks++;
    if (task_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_duplicate: got %0b expected 0", name, task_valid_o);
    end
  endtask

  task automatic test_lookup();
    single_cmd("lookup", {2'd1, 32'hCAFE0001, 32'h12345678}, 8'h08, 11'h000);
  endtask

  task automatic test_write();
    @(posedge clk_i); #1;
    head_wr_en_i      = 1'b1;
    head_wr_bucket_i  = 8'h08;
    head_wr_ptr_i     = 10'h015;
    head_wr_ptr_val_i = 1'b1;
    @(posedge clk_i); #1;
    head_wr_en_i = 1'b0;
    head_model[8'h08] = {10'h015, 1'b1};
    single_cmd("write", {2'd2, 32'h0BAD0002, 32'h12345678}, 8'h08, {10'h015, 1'b1});
  endtask

  task automatic test_forward();
    logic [65:0] c;
    logic [84:0] e;
    c = {2'd3, 32'h00000F0F, 32'h12345678};
    @(posedge clk_i); #1;
    task_ready_i      = 1'b1;
    cmd_valid_i       = 1'b1;
    cmd_i             = c;
    head_wr_en_i      = 1'b1;
    head_wr_bucket_i  = 8'h08;
    head_wr_ptr_i     = 10'h020;
    head_wr_ptr_val_i = 1'b1;
    @(posedge clk_i); #1;
    cmd_valid_i   = 1'b0;
    head_wr_ptr_i = 10'h021;
    head_model[8'h08] = {10'h021, 1'b1};
    exp_q.push_back(expected_task(c));
    @(posedge clk_i); #1;
    head_wr_en_i = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (task_valid_o !== 1'b1 || task_o !== e || task_o[10:1] !== 10'h021) begin
      failures++;
      $display("FAIL forward_task: got v=%0b task=%h expected v=1 task=%h", task_valid_o, task_o, e);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_back_to_back();
    int recvd = 0;
    bit stalled_prev = 0;
    logic [84:0] prev = '0;
    fork
      begin
        @(posedge clk_i); #1;
        for (int i = 0; i < 8; i++) begin
          logic [65:0] c;
          bit acc;
          int guard;
          c = {2'($urandom_range(0, 3)), 32'($urandom), 32'($urandom)};
          cmd_valid_i = 1'b1;
          cmd_i       = c;
          acc   = 0;
          guard = 0;
          while (!acc && guard < 200) begin
            @(negedge clk_i);
            acc = cmd_ready_o;
            @(posedge clk_i);
            guard++;
          end
          if (!acc) begin
            checks++;
            failures++;
            $display("FAIL b2b_accept_timeout: got no accept for cmd %0d expected accept", i);
            break;
          end
          exp_q.push_back(expected_task(c));
          #1;
        end
        cmd_valid_i = 1'b0;
      end
      begin
        for (int cyc = 0; cyc < 400 && recvd < 8; cyc++) begin
          @(posedge clk_i); #1;
          task_ready_i = 1'($urandom_range(0, 1));
          @(negedge clk_i);
          if (stalled_prev) begin
            checks++;
            if (task_valid_o !== 1'b1 || task_o !== prev) begin
              failures++;
              $display("FAIL b2b_stable: got v=%0b task=%h expected v=1 task=%h",
                       task_valid_o, task_o, prev);
            end
          end
          if (task_valid_o && task_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL b2b_extra_task: got task=%h expected none", task_o);
            end else begin
              logic [84:0] e;
              e = exp_q.pop_front();
              if (task_o !== e) begin
                failures++;
                $display("FAIL b2b_task%0d: got %h expected %h", recvd, task_o, e);
              end
            end
            recvd++;
          end
          stalled_prev = task_valid_o && !task_ready_i;
          prev = task_o;
        end
      end
    join
    checks++;
    if (recvd !== 8) begin
      failures++;
      $display("FAIL b2b_count: got %0d tasks expected 8", recvd);
    end
    @(posedge clk_i); #1;
    task_ready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    checks++;
    if (task_valid_o !== 1'b0 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL b2b_leftover: got v=%0b pending=%0d expected v=0 pending=0",
               task_valid_o, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    bit saw_valid = 0;
    @(posedge clk_i); #1;
    task_ready_i = 1'b0;
    cmd_valid_i  = 1'b1;
    cmd_i        = {2'd0, 32'h1, 32'h12345678};
    @(posedge clk_i); #1;
    cmd_i = {2'd0, 32'h2, 32'h0000ABCD};
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    checks++;
    if (task_valid_o !== 1'b1 || cmd_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL midrst_full: got v=%0b rdy=%0b expected v=1 rdy=0", task_valid_o, cmd_ready_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++;
    if ({task_valid_o, cmd_ready_o, init_done_o} !== 3'b000 || task_o !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: got v=%0b rdy=%0b done=%0b task=%h expected all 0",
               task_valid_o, cmd_ready_o, init_done_o, task_o);
    end
    exp_q.delete();
    clear_model();
    @(negedge clk_i);
    rst_i = 1'b0;
    task_ready_i = 1'b1;
    wait_init("midrst");
    repeat (4) begin
      @(posedge clk_i); #1;
      if (task_valid_o) saw_valid = 1;
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_stale_task: got valid=1 expected 0");
    end
    single_cmd("midrst_cleared", {2'd1, 32'h3, 32'h12345678}, 8'h08, 11'h000);
  endtask

  initial begin
    test_reset();
    test_lookup();
    test_write();
    test_forward();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
